// File: rtl/byang_inv_arbiter_pkg.sv
// Shared constants and FSM state encoding for the byang_inv arbiter.
// BYANG_WIDTH must track the operand width of the byang_inv core.
package byang_inv_arbiter_pkg;

  localparam int BYANG_WIDTH = 256;
  localparam int ARB_STATE_W = 2;

  typedef enum logic [ARB_STATE_W-1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT    = 2'd2,
    ARB_DELIVER = 2'd3
  } arb_state_e;

endpackage

// File: rtl/byang_inv_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr,
// wrapping modulo N, returned as one-hot grant plus binary index.
module byang_inv_arbiter_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  localparam logic [IDX_W:0] N_EXT = (IDX_W+1)'(N);

  logic [N-1:0]     w_rot;
  logic [IDX_W-1:0] w_off;
  logic [IDX_W:0]   w_sum;

  // Rotate so that bit 0 of w_rot is the requester the pointer names.
  assign w_rot = (i_req >> i_ptr) | (i_req << (N_EXT - {1'b0, i_ptr}));

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first, so
    // no path through the block leaves it unassigned and infers a latch.
    w_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if ((w_rot & (N'(1) << k)) != '0) w_off = k[IDX_W-1:0];
    end
  end

  assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx   = (w_sum >= N_EXT) ? IDX_W'(w_sum - N_EXT) : IDX_W'(w_sum);
  assign o_any   = |i_req;
  assign o_grant = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/byang_inv_arbiter.sv
// Shares one byang_inv modular-inverse core between N_REQ requesters with
// round-robin grant, one operation in flight, and last-op latency reporting.
module byang_inv_arbiter
  import byang_inv_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = BYANG_WIDTH,
  parameter int LAT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  output logic [N_REQ-1:0]       resp_valid,
  input  logic [N_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   inv_valid_in,
  input  logic                   inv_ready_in,
  output logic [WIDTH-1:0]       inv_a,
  input  logic                   inv_valid_out,
  output logic                   inv_ready_out,
  input  logic [WIDTH-1:0]       inv_result,
  output logic                   busy,
  output logic [LAT_W-1:0]       last_lat
);

  localparam int              IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_e       r_state, w_next_state;
  logic [IDX_W-1:0] r_rr_ptr, r_owner;
  logic [WIDTH-1:0] r_op, r_res;
  logic [LAT_W-1:0] r_lat_cnt, r_last_lat;

  logic [N_REQ-1:0] w_grant;
  logic [IDX_W-1:0] w_grant_idx;
  logic             w_any;
  logic [N_REQ-1:0] w_owner_oh;
  logic [LAT_W-1:0] w_lat_inc;
  logic [WIDTH-1:0] w_req_op [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign w_req_op[g] = req_a[g*WIDTH +: WIDTH];
  end

  byang_inv_arbiter_rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign w_owner_oh = N_REQ'(1) << r_owner;
  assign w_lat_inc  = (r_lat_cnt == '1) ? r_lat_cnt : r_lat_cnt + LAT_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    req_ready     = '0;
    inv_valid_in  = 1'b0;
    inv_ready_out = 1'b0;
    resp_valid    = '0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          req_ready    = w_grant;
          w_next_state = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        inv_valid_in = 1'b1;
        if (inv_ready_in) w_next_state = ARB_WAIT;
      end
      ARB_WAIT: begin
        inv_ready_out = 1'b1;
        if (inv_valid_out) w_next_state = ARB_DELIVER;
      end
      ARB_DELIVER: begin
        resp_valid = w_owner_oh;
        if ((resp_ready & w_owner_oh) != '0) w_next_state = ARB_IDLE;
      end
      default: w_next_state = ARB_IDLE;
    endcase
    // Nothing may look accepted while reset is discarding the transfer.
    if (rst) begin
      req_ready     = '0;
      inv_valid_in  = 1'b0;
      inv_ready_out = 1'b0;
      resp_valid    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_op       <= '0;
      r_res      <= '0;
      r_lat_cnt  <= '0;
      r_last_lat <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_op     <= w_req_op[w_grant_idx];
            r_owner  <= w_grant_idx;
            r_rr_ptr <= (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + IDX_W'(1);
          end
        end
        ARB_ISSUE: begin
          if (inv_ready_in) r_lat_cnt <= '0;
        end
        ARB_WAIT: begin
          // last_lat counts the edge that delivers inv_valid_out as well.
          if (inv_valid_out) begin
            r_res      <= inv_result;
            r_last_lat <= w_lat_inc;
          end else begin
            r_lat_cnt  <= w_lat_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign inv_a     = r_op;
  assign resp_data = r_res;
  assign busy      = (r_state != ARB_IDLE);
  assign last_lat  = r_last_lat;

endmodule

// File: tb/tb_byang_inv_arbiter.sv
// Bench for byang_inv_arbiter: behavioural byang_inv core with programmable
// latency, round-robin reference model and modular-inverse result model.
module tb_byang_inv_arbiter;

  localparam int N  = 4;
  localparam int W  = 256;
  localparam int LW = 16;
  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   resp_ready = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N-1:0]   req_ready, resp_valid;
  logic [W-1:0]   resp_data, inv_a, inv_result;
  logic           inv_valid_in, inv_ready_in, inv_valid_out, inv_ready_out, busy;
  logic [LW-1:0]  last_lat;

  int n_pass  = 0;
  int n_total = 0;
  int ptr_m   = 0;
  int m_lat   = 2;
  bit m_hold  = 1'b0;

  byang_inv_arbiter #(.N_REQ(N), .WIDTH(W), .LAT_W(LW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .inv_valid_in  (inv_valid_in),
    .inv_ready_in  (inv_ready_in),
    .inv_a         (inv_a),
    .inv_valid_out (inv_valid_out),
    .inv_ready_out (inv_ready_out),
    .inv_result    (inv_result),
    .busy          (busy),
    .last_lat      (last_lat)
  );

  always #5 clk = ~clk;

  // a^(p-2) mod p by square-and-multiply (Fermat); 0 maps to 0.
  function automatic logic [255:0] modinv(input logic [255:0] a);
    logic [511:0] r, b, pp;
    logic [255:0] e;
    pp = {256'd0, P};
    e  = P - 256'd2;
    r  = 512'd1;
    b  = {256'd0, a} % pp;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = (r * b) % pp;
      b = (b * b) % pp;
    end
    return r[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Round-robin rule: first asserted requester at or after ptr, modulo N.
  function automatic int rr_expect(input logic [N-1:0] v, input int ptr);
    int idx, res;
    bit found;
    res = -1;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (ptr + k) % N;
      if (!found && ((v >> idx) & 4'd1) != 4'd0) begin
        res = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Core model: accepts one op, raises valid_out m_lat cycles after accept.
  logic [W-1:0] m_op;
  logic         m_busy;
  int           m_cnt;
  assign inv_ready_in = !m_busy && !m_hold;

  always @(posedge clk) begin
    if (rst) begin
      m_busy        <= 1'b0;
      m_cnt         <= 0;
      inv_valid_out <= 1'b0;
      inv_result    <= '0;
    end else if (!m_busy) begin
      if (inv_valid_in && inv_ready_in) begin
        m_busy <= 1'b1;
        m_op   <= inv_a;
        m_cnt  <= 1;
      end
    end else if (!inv_valid_out) begin
      if (m_cnt >= m_lat - 1) begin
        inv_valid_out <= 1'b1;
        inv_result    <= modinv(m_op);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (inv_ready_out) begin
      inv_valid_out <= 1'b0;
      m_busy        <= 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [255:0] v);
    req_a[i*W +: W] = v;
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    #1;
    for (int c = 0; c < budget && !ok; c++) begin
      if (req_ready != '0) ok = 1'b1;
      else step();
    end
  endtask

  task automatic wait_resp(input int budget, output bit ok);
    ok = 1'b0;
    #1;
    for (int c = 0; c < budget && !ok; c++) begin
      if (resp_valid != '0) ok = 1'b1;
      else step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b0001;
    step();
    step();
    n_total++;
    if (req_ready !== 4'd0) $display("FAIL rst_req_ready: got %b want 0000", req_ready);
    else n_pass++;
    rst = 1'b0;
    req_valid = '0;
    #1;
    n_total++;
    if ({req_ready, resp_valid, inv_valid_in, inv_ready_out, busy} !== 11'd0)
      $display("FAIL rst_handshake: got %b want 0", {req_ready, resp_valid, inv_valid_in, inv_ready_out, busy});
    else n_pass++;
    n_total++;
    if (last_lat !== 16'd0) $display("FAIL rst_last_lat: got %0d want 0", last_lat);
    else n_pass++;
    n_total++;
    if (inv_a !== '0 || resp_data !== '0) $display("FAIL rst_regs: inv_a=%h resp_data=%h want 0", inv_a, resp_data);
    else n_pass++;
    ptr_m = 0;
  endtask

  task automatic test_single();
    logic [511:0] prod;
    logic [255:0] exp_inv;
    bit ok;
    m_lat = 742;
    exp_inv = modinv(256'd3);
    set_op(0, 256'd3);
    req_valid = 4'b0001;
    #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL t1_grant: got %b want 0001", req_ready);
    else n_pass++;
    step();
    n_total++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) $display("FAIL t1_one_cycle: req_ready=%b busy=%b want 0000/1", req_ready, busy);
    else n_pass++;
    req_valid = '0;
    ptr_m = 1;
    wait_resp(1000, ok);
    n_total++;
    if (!ok || resp_valid !== 4'b0001) $display("FAIL t1_resp_valid: got %b want 0001", resp_valid);
    else n_pass++;
    n_total++;
    if (resp_data !== exp_inv) $display("FAIL t1_data: got %h want %h", resp_data, exp_inv);
    else n_pass++;
    prod = ({256'd0, resp_data} * 512'd3) % {256'd0, P};
    n_total++;
    if (prod !== 512'd1) $display("FAIL t1_inverse_product: 3*result mod p = %h want 1", prod);
    else n_pass++;
    n_total++;
    if (last_lat !== 16'd742) $display("FAIL t1_last_lat: got %0d want 742", last_lat);
    else n_pass++;
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
    n_total++;
    if (busy !== 1'b0 || resp_valid !== 4'd0) $display("FAIL t1_release: busy=%b resp_valid=%b want 0/0000", busy, resp_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [255:0] ops [N];
    logic [255:0] op;
    logic [N-1:0] exp_oh;
    int g_exp;
    bit ok, got, stray;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr_m = 0;
    for (int i = 0; i < N; i++) begin
      ops[i] = rand256();
      set_op(i, ops[i]);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      m_lat = $urandom_range(20, 2);
      wait_grant(20, ok);
      g_exp  = rr_expect(req_valid, ptr_m);
      exp_oh = 4'b0001 << g_exp;
      n_total++;
      if (!ok || req_ready !== exp_oh) $display("FAIL t2_grant[%0d]: got %b want %b", k, req_ready, exp_oh);
      else n_pass++;
      op = ops[g_exp];
      ptr_m = (g_exp + 1) % N;
      step();
      ops[g_exp] = rand256();
      set_op(g_exp, ops[g_exp]);
      got = 1'b0;
      stray = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        if (resp_valid != '0) got = 1'b1;
        else begin
          if (req_ready != '0) stray = 1'b1;
          step();
        end
      end
      n_total++;
      if (!got || resp_valid !== exp_oh) $display("FAIL t2_owner[%0d]: resp_valid=%b want %b", k, resp_valid, exp_oh);
      else n_pass++;
      n_total++;
      if (resp_data !== modinv(op)) $display("FAIL t2_data[%0d]: got %h want %h", k, resp_data, modinv(op));
      else n_pass++;
      n_total++;
      if (stray) $display("FAIL t2_no_grant_in_flight[%0d]: req_ready seen while busy", k);
      else n_pass++;
      resp_ready = ~exp_oh;
      step();
      n_total++;
      if (resp_valid !== exp_oh) $display("FAIL t2_ignore_other_ready[%0d]: got %b want %b", k, resp_valid, exp_oh);
      else n_pass++;
      resp_ready = exp_oh;
      step();
      resp_ready = '0;
    end
    req_valid = '0;
  endtask

  task automatic test_resp_stall();
    logic [255:0] op, exp_inv;
    bit ok, bad_resp, bad_busy, bad_grant;
    m_lat = 5;
    op = rand256();
    exp_inv = modinv(op);
    set_op(2, op);
    req_valid = 4'b0100;
    wait_grant(10, ok);
    n_total++;
    if (!ok || req_ready !== (4'b0001 << rr_expect(4'b0100, ptr_m)))
      $display("FAIL t3_grant: got %b want 0100", req_ready);
    else n_pass++;
    ptr_m = 3;
    step();
    req_valid = 4'b1011;
    wait_resp(50, ok);
    n_total++;
    if (!ok || resp_valid !== 4'b0100 || resp_data !== exp_inv)
      $display("FAIL t3_resp: resp_valid=%b data=%h want 0100/%h", resp_valid, resp_data, exp_inv);
    else n_pass++;
    bad_resp = 1'b0;
    bad_busy = 1'b0;
    bad_grant = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (resp_valid !== 4'b0100 || resp_data !== exp_inv) bad_resp = 1'b1;
      if (busy !== 1'b1) bad_busy = 1'b1;
      if (req_ready !== 4'd0) bad_grant = 1'b1;
      step();
    end
    n_total++;
    if (bad_resp) $display("FAIL t3_resp_stable: resp changed during stall (now %b/%h)", resp_valid, resp_data);
    else n_pass++;
    n_total++;
    if (bad_busy) $display("FAIL t3_busy: busy dropped during stall, now %b", busy);
    else n_pass++;
    n_total++;
    if (bad_grant) $display("FAIL t3_no_grant: req_ready asserted during stall, now %b", req_ready);
    else n_pass++;
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    ptr_m = 0;
    n_total++;
    if (busy !== 1'b0 || resp_valid !== 4'd0 || resp_data !== '0)
      $display("FAIL t3_rst_clears: busy=%b resp_valid=%b data=%h want 0", busy, resp_valid, resp_data);
    else n_pass++;
  endtask

  task automatic test_issue_stall();
    logic [255:0] op;
    bit ok, bad_valid, bad_a, bad_rdy;
    m_hold = 1'b1;
    m_lat = 9;
    op = rand256();
    set_op(3, op);
    req_valid = 4'b1000;
    wait_grant(10, ok);
    n_total++;
    if (!ok || req_ready !== (4'b0001 << rr_expect(4'b1000, ptr_m)))
      $display("FAIL t4_grant: got %b want 1000", req_ready);
    else n_pass++;
    ptr_m = 0;
    step();
    req_valid = '0;
    bad_valid = 1'b0;
    bad_a = 1'b0;
    bad_rdy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (inv_valid_in !== 1'b1) bad_valid = 1'b1;
      if (inv_a !== op) bad_a = 1'b1;
      if (inv_ready_out !== 1'b0) bad_rdy = 1'b1;
      step();
    end
    n_total++;
    if (bad_valid) $display("FAIL t4_valid_in_held: inv_valid_in dropped, now %b", inv_valid_in);
    else n_pass++;
    n_total++;
    if (bad_a) $display("FAIL t4_inv_a_stable: got %h want %h", inv_a, op);
    else n_pass++;
    n_total++;
    if (bad_rdy) $display("FAIL t4_ready_out_idle: inv_ready_out asserted in issue, now %b", inv_ready_out);
    else n_pass++;
    m_hold = 1'b0;
    wait_resp(50, ok);
    n_total++;
    if (!ok || last_lat !== 16'd9) $display("FAIL t4_last_lat: got %0d want 9", last_lat);
    else n_pass++;
    n_total++;
    if (resp_data !== modinv(op)) $display("FAIL t4_data: got %h want %h", resp_data, modinv(op));
    else n_pass++;
    resp_ready = 4'b1000;
    step();
    resp_ready = '0;
  endtask

  task automatic test_rst_in_wait();
    logic [255:0] op1, op3;
    bit ok;
    m_lat = 30;
    set_op(1, rand256());
    req_valid = 4'b0010;
    wait_grant(10, ok);
    n_total++;
    if (!ok || req_ready !== (4'b0001 << rr_expect(4'b0010, ptr_m)))
      $display("FAIL t5_first_grant: got %b want 0010", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    step();
    step();
    n_total++;
    if (inv_ready_out !== 1'b1) $display("FAIL t5_in_wait: inv_ready_out=%b want 1", inv_ready_out);
    else n_pass++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    ptr_m = 0;
    n_total++;
    if ({req_ready, resp_valid, inv_valid_in, inv_ready_out, busy} !== 11'd0)
      $display("FAIL t5_rst_handshake: got %b want 0", {req_ready, resp_valid, inv_valid_in, inv_ready_out, busy});
    else n_pass++;
    n_total++;
    if (last_lat !== 16'd0 || inv_a !== '0 || resp_data !== '0)
      $display("FAIL t5_rst_regs: last_lat=%0d inv_a=%h resp_data=%h want 0", last_lat, inv_a, resp_data);
    else n_pass++;
    m_lat = 4;
    op1 = rand256();
    op3 = rand256();
    set_op(1, op1);
    set_op(3, op3);
    req_valid = 4'b1010;
    wait_grant(10, ok);
    n_total++;
    if (!ok || req_ready !== (4'b0001 << rr_expect(4'b1010, ptr_m)))
      $display("FAIL t5_ptr_reset: got %b want 0010", req_ready);
    else n_pass++;
    ptr_m = 2;
    step();
    req_valid = '0;
    wait_resp(50, ok);
    n_total++;
    if (!ok || resp_valid !== 4'b0010 || resp_data !== modinv(op1))
      $display("FAIL t5_fresh_op: resp_valid=%b data=%h want 0010/%h", resp_valid, resp_data, modinv(op1));
    else n_pass++;
    n_total++;
    if (last_lat !== 16'd4) $display("FAIL t5_last_lat: got %0d want 4", last_lat);
    else n_pass++;
    resp_ready = 4'b0010;
    step();
    resp_ready = '0;
  endtask

  task automatic test_saturate();
    logic [255:0] op;
    bit ok;
    m_lat = 70000;
    op = rand256();
    set_op(0, op);
    req_valid = 4'b0001;
    wait_grant(10, ok);
    n_total++;
    if (!ok || req_ready !== (4'b0001 << rr_expect(4'b0001, ptr_m)))
      $display("FAIL t6_grant: got %b want 0001", req_ready);
    else n_pass++;
    ptr_m = 1;
    step();
    req_valid = '0;
    wait_resp(70100, ok);
    n_total++;
    if (!ok || last_lat !== 16'hFFFF) $display("FAIL t6_saturate: got %h want ffff", last_lat);
    else n_pass++;
    n_total++;
    if (resp_data !== modinv(op)) $display("FAIL t6_data: got %h want %h", resp_data, modinv(op));
    else n_pass++;
    resp_ready = 4'b0001;
    step();
    resp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_resp_stall();
    test_issue_stall();
    test_rst_in_wait();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached after %0d/%0d checks", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule
